ed_result_unpacker: RTL and testbench

Receive-side consumer of the tagged energy-detection stream. Each 32-bit word carries the per-window detection flag in bit 31 and a 31-bit squared-magnitude sample in bits 30:0. The block splits the stream back into windows of `window_size` samples and strips the flag. In gated mode it forwards only samples from detected windows. It buffers the output in a small FIFO with a valid/ready handshake and keeps per-window statistics plus sticky error flags.

---
 rtl/ed_result_unpacker_pkg.sv | 22 ++
 rtl/ed_result_unpacker_fifo_sync_fwft.sv | 53 +++++
 rtl/ed_result_unpacker.sv | 128 ++++++++++++
 tb/tb_ed_result_unpacker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ed_result_unpacker_pkg.sv
// Shared types for the energy-detection result unpacker: widths, FSM states
// and the packed FIFO entry layout.
package ed_pkg;

  localparam int WIN_W    = 10;
  localparam int SAMPLE_W = 31;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_WIN = 1'b1
  } state_t;

  typedef struct packed {
    logic                flag;
    logic                first;
    logic                last;
    logic [SAMPLE_W-1:0] sample;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/ed_result_unpacker_fifo_sync_fwft.sv
// Generic first-word-fall-through synchronous FIFO. The head is visible on
// dout whenever empty is low; dout reads as zero while empty.
module fifo_sync_fwft #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ed_result_unpacker.sv
// Splits the tagged energy-detection stream back into windows, strips the
// flag, optionally gates undetected windows and buffers the result.
//
// state  | meaning
// IDLE   | waiting for the first sample of a window
// IN_WIN | inside a window of ws_l samples, cnt = index of next sample
module ed_result_unpacker
  import ed_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                sclr,
  input  logic [WIN_W-1:0]    window_size,
  input  logic                gate_en,
  input  logic [31:0]         din,
  input  logic                din_valid,
  output logic [SAMPLE_W-1:0] dout,
  output logic                dout_flag,
  output logic                dout_first,
  output logic                dout_last,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [CNT_W-1:0]    win_count,
  output logic [CNT_W-1:0]    det_count,
  output logic                flag_err,
  output logic                ovf
);

  state_t           state;
  logic [WIN_W-1:0] ws_l;
  logic [WIN_W-1:0] cnt;
  logic             win_flag;
  logic             gate_l;

  logic   start;
  logic   mid;
  logic   cur_flag;
  logic   cur_gate;
  logic   is_last;
  logic   complete;
  logic   push_req;
  logic   pop;
  logic   full;
  logic   empty;
  entry_t push_entry;
  entry_t head;

  // The starting sample is classified from the live inputs; later samples use the latched window state.
  always_comb begin
    start    = (state == IDLE) && din_valid && (window_size != '0);
    mid      = (state == IN_WIN) && din_valid;
    cur_flag = start ? din[31] : win_flag;
    cur_gate = start ? gate_en : gate_l;
    is_last  = start ? (window_size == WIN_W'(1)) : (cnt == ws_l - WIN_W'(1));
    complete = (start || mid) && is_last;
    push_req = (start || mid) && (!cur_gate || cur_flag);
    push_entry.flag   = cur_flag;
    push_entry.first  = start;
    push_entry.last   = is_last;
    push_entry.sample = din[SAMPLE_W-1:0];
  end

  assign pop = dout_valid && dout_ready;

  always_ff @(posedge clock) begin
    if (sclr) begin
      state     <= IDLE;
      ws_l      <= '0;
      cnt       <= '0;
      win_flag  <= 1'b0;
      gate_l    <= 1'b0;
      win_count <= '0;
      det_count <= '0;
      flag_err  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ws_l     <= window_size;
            win_flag <= din[31];
            gate_l   <= gate_en;
            if (!is_last) begin
              cnt   <= WIN_W'(1);
              state <= IN_WIN;
            end
          end
        end
        IN_WIN: begin
          if (mid) begin
            if (din[31] != win_flag) flag_err <= 1'b1;
            if (is_last) state <= IDLE;
            else         cnt   <= cnt + WIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (complete) begin
        win_count <= win_count + CNT_W'(1);
        if (cur_flag && (det_count != '1)) det_count <= det_count + CNT_W'(1);
      end
      if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  fifo_sync_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .sclr  (sclr),
    .push  (push_req),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign dout_valid = !empty;
  assign dout       = head.sample;
  assign dout_flag  = head.flag;
  assign dout_first = head.first;
  assign dout_last  = head.last;

endmodule

// File: tb/tb_ed_result_unpacker.sv
// Randomised and directed bench for ed_result_unpacker against a window-level
// reference model with an output queue.
module tb_ed_result_unpacker;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic        clock = 1'b0;
  logic        sclr = 1'b0;
  logic [9:0]  window_size = '0;
  logic        gate_en = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic [30:0] dout;
  logic        dout_flag, dout_first, dout_last, dout_valid;
  logic        dout_ready = 1'b0;
  logic [CNT_W-1:0] win_count, det_count;
  logic        flag_err, ovf;

  ed_result_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .sclr(sclr), .window_size(window_size), .gate_en(gate_en),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_flag(dout_flag),
    .dout_first(dout_first), .dout_last(dout_last), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .win_count(win_count), .det_count(det_count),
    .flag_err(flag_err), .ovf(ovf)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [33:0]      q[$];
  bit               m_in;
  int               m_idx, m_ws;
  bit               m_flag, m_gate, m_ferr, m_ovf;
  logic [CNT_W-1:0] m_win, m_det;
  int               n_popped, n_fl;
  logic [30:0]      popped[$];

  task automatic model_reset();
    q.delete();
    m_in = 0; m_idx = 0; m_ws = 0; m_flag = 0; m_gate = 0;
    m_ferr = 0; m_ovf = 0; m_win = '0; m_det = '0;
  endtask

  // One clock: score a pop, feed the model, advance, then compare status.
  task automatic tick();
    bit start, last;
    if (!sclr) begin
      if (dout_valid && dout_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_empty: got dout=%h, required no entry", dout);
        end else begin
          if ({dout_flag, dout_first, dout_last, dout} !== q[0]) begin
            miscompares++;
            $display("FAIL head: got %h, required %h",
                     {dout_flag, dout_first, dout_last, dout}, q[0]);
          end
          void'(q.pop_front());
        end
        n_popped++;
        popped.push_back(dout);
        if (dout_first && dout_last) n_fl++;
      end
      if (din_valid) begin
        start = !m_in && (window_size != 0);
        if (start || m_in) begin
          if (start) begin
            m_ws = window_size; m_flag = din[31]; m_gate = gate_en; m_idx = 0;
          end else if (din[31] != m_flag) m_ferr = 1;
          last = (m_idx == m_ws - 1);
          if (!m_gate || m_flag) begin
            if (q.size() < DEPTH) q.push_back({m_flag, m_idx == 0, last, din[30:0]});
            else m_ovf = 1;
          end
          if (last) begin
            m_win++;
            if (m_flag && m_det != '1) m_det++;
            m_in = 0;
          end else begin
            m_in = 1;
            m_idx++;
          end
        end
      end
    end
    @(posedge clock);
    #1;
    if (sclr) model_reset();
    vectors++;
    if ({dout_valid, win_count, det_count, flag_err, ovf} !==
        {q.size() != 0, m_win, m_det, m_ferr, m_ovf}) begin
      miscompares++;
      $display("FAIL status: got valid=%0b win=%0d det=%0d ferr=%0b ovf=%0b, required valid=%0b win=%0d det=%0d ferr=%0b ovf=%0b",
               dout_valid, win_count, det_count, flag_err, ovf,
               q.size() != 0, m_win, m_det, m_ferr, m_ovf);
    end
  endtask

  task automatic reset_dut();
    din_valid = 0; sclr = 1;
    tick();
    sclr = 0;
    n_popped = 0; n_fl = 0; popped.delete();
  endtask

  task automatic send(input bit flag, input logic [30:0] s);
    din = {flag, s}; din_valid = 1;
    tick();
    din_valid = 0;
  endtask

  task automatic drain();
    din_valid = 0; dout_ready = 1;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && !dout_valid) break;
      tick();
    end
    vectors++;
    if (q.size() != 0 || dout_valid) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    sclr = 1; tick(); tick(); sclr = 0;
    vectors++;
    if ({dout_valid, dout_flag, dout_first, dout_last, dout, win_count, det_count, flag_err, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got valid=%0b dout=%h win=%0d det=%0d ferr=%0b ovf=%0b, required all 0",
               dout_valid, dout, win_count, det_count, flag_err, ovf);
    end
  endtask

  task automatic test_ungated();
    reset_dut();
    window_size = 4; gate_en = 0; dout_ready = 1;
    send(1, 10); send(1, 20); send(1, 30); send(1, 40);
    drain();
    vectors++;
    if (popped.size() != 4 || popped[0] !== 31'd10 || popped[1] !== 31'd20 ||
        popped[2] !== 31'd30 || popped[3] !== 31'd40) begin
      miscompares++;
      $display("FAIL ungated_order: got %0d samples, required 10,20,30,40", popped.size());
    end
    vectors++;
    if (win_count !== 16'd1 || det_count !== 16'd1) begin
      miscompares++;
      $display("FAIL ungated_counts: got win=%0d det=%0d, required 1 1", win_count, det_count);
    end
  endtask

  task automatic test_gated();
    bit flags[3] = '{0, 1, 0};
    reset_dut();
    window_size = 3; gate_en = 1; dout_ready = 1;
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 3; k++) send(flags[w], 31'(100 + w * 10 + k));
    drain();
    vectors++;
    if (n_popped != 3 || popped[0] !== 31'd110 || popped[2] !== 31'd112) begin
      miscompares++;
      $display("FAIL gated_output: got %0d samples, required 3 (110..112)", n_popped);
    end
    vectors++;
    if (win_count !== 16'd3 || det_count !== 16'd1) begin
      miscompares++;
      $display("FAIL gated_counts: got win=%0d det=%0d, required 3 1", win_count, det_count);
    end
    gate_en = 0;
  endtask

  task automatic test_flag_change();
    reset_dut();
    window_size = 4; gate_en = 1; dout_ready = 1;
    send(1, 1); send(1, 2);
    vectors++;
    if (flag_err !== 1'b0) begin
      miscompares++; $display("FAIL flag_err_early: got %0b, required 0", flag_err);
    end
    send(0, 3);
    vectors++;
    if (flag_err !== 1'b1) begin
      miscompares++; $display("FAIL flag_err_set: got %0b, required 1", flag_err);
    end
    send(1, 4);
    drain();
    vectors++;
    if (n_popped != 4 || det_count !== 16'd1 || flag_err !== 1'b1) begin
      miscompares++;
      $display("FAIL flag_change: got n=%0d det=%0d ferr=%0b, required 4 1 1", n_popped, det_count, flag_err);
    end
    gate_en = 0;
  endtask

  task automatic test_overflow();
    reset_dut();
    window_size = 4; gate_en = 0; dout_ready = 0;
    din_valid = 1;
    for (int i = 0; i < 20; i++) begin
      din = {1'b1, 31'(500 + i)};
      tick();
      if (i == 15 || i == 16) begin
        vectors++;
        if (ovf !== (i == 16)) begin
          miscompares++;
          $display("FAIL ovf_sample%0d: got %0b, required %0b", i + 1, ovf, i == 16);
        end
      end
    end
    din_valid = 0;
    drain();
    vectors++;
    if (n_popped != 16 || popped[0] !== 31'd500 || popped[15] !== 31'd515) begin
      miscompares++;
      $display("FAIL ovf_contents: got %0d samples, required 16 (500..515)", n_popped);
    end
  endtask

  task automatic test_ws_edges();
    reset_dut();
    window_size = 1; gate_en = 0; dout_ready = 1;
    for (int i = 0; i < 6; i++) send(i[0], 31'(i));
    drain();
    vectors++;
    if (n_fl != 6 || win_count !== 16'd6 || det_count !== 16'd3) begin
      miscompares++;
      $display("FAIL ws1: got first_last=%0d win=%0d det=%0d, required 6 6 3", n_fl, win_count, det_count);
    end
    reset_dut();
    window_size = 0;
    for (int i = 0; i < 5; i++) send(1, 31'(i));
    drain();
    vectors++;
    if (n_popped != 0 || win_count !== '0 || det_count !== '0) begin
      miscompares++;
      $display("FAIL ws0: got n=%0d win=%0d det=%0d, required 0 0 0", n_popped, win_count, det_count);
    end
    reset_dut();
    window_size = 4;
    send(0, 1); send(0, 2);
    window_size = 2;
    send(0, 3);
    vectors++;
    if (win_count !== '0) begin
      miscompares++; $display("FAIL ws_change_hold: got win=%0d, required 0", win_count);
    end
    send(0, 4);
    send(0, 5); send(0, 6);
    vectors++;
    if (win_count !== 16'd2) begin
      miscompares++; $display("FAIL ws_change_next: got win=%0d, required 2", win_count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    window_size = 4; gate_en = 0; dout_ready = 0;
    send(1, 7); send(1, 8);
    sclr = 1; tick(); sclr = 0;
    vectors++;
    if ({dout_valid, dout_flag, dout_first, dout_last, dout, win_count, det_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%0b dout=%h, required 0", dout_valid, dout);
    end
    send(1, 9);
    vectors++;
    if (dout_valid !== 1'b1 || dout_first !== 1'b1 || dout !== 31'd9) begin
      miscompares++;
      $display("FAIL reset_restart: got valid=%0b first=%0b dout=%0d, required 1 1 9", dout_valid, dout_first, dout);
    end
    drain();
  endtask

  task automatic test_random();
    bit wflag;
    reset_dut();
    wflag = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) window_size = 10'($urandom_range(0, 6));
      gate_en    = $urandom_range(0, 1);
      dout_ready = ($urandom_range(0, 3) != 0);
      din_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) wflag = ~wflag;
      din = {($urandom_range(0, 19) == 0) ? ~wflag : wflag, 31'($urandom)};
      tick();
    end
    din_valid = 0;
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ungated();
    test_gated();
    test_flag_change();
    test_overflow();
    test_ws_edges();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
